// File: rtl/video_cmd_issuer.sv
// Issues 64-bit data-mover commands into a BRAM-mapped target queue as two
// back-to-back 32-bit writes after polling occupancy. Optional macro: VIDEO_CMD_ISSUER_CREDIT_EN.
module video_cmd_issuer #(
  parameter int DEPTH_LOG2 = 7,
  parameter int POLL_GAP   = 4
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_sel,
  input  logic [63:0] cmd_data,
  output logic        bram_en,
  output logic [3:0]  bram_we,
  output logic [11:0] bram_addr,
  output logic [31:0] bram_wrdata,
  input  logic [31:0] bram_rddata,
  output logic        busy,
  output logic [15:0] src_issued,
  output logic [15:0] dest_issued
);

  localparam int OW = DEPTH_LOG2 + 1;
  localparam logic [OW-1:0] CAPACITY = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [7:0] GAP_LOAD = 8'(POLL_GAP - 1);

  typedef enum logic [2:0] {IDLE, POLL, WAIT, BACKOFF, WR_LO, WR_HI} state_t;

  state_t        state, next_state;
  logic          sel_q;
  logic [63:0]   data_q;
  logic [7:0]    gap_cnt, gap_cnt_d;
  logic          accept;
  logic          sel_n;
  logic [63:0]   data_n;
  logic [11:0]   base_n;
  logic [OW-1:0] occupancy;
  logic          q_full;
  logic          en_d;
  logic [3:0]    we_d;
  logic [11:0]   addr_d;
  logic [31:0]   wrdata_d;
  logic          src_inc, dest_inc;
  logic          unused_rd;

  assign occupancy = bram_rddata[DEPTH_LOG2:0];
  assign q_full    = occupancy >= CAPACITY;
  assign unused_rd = ^bram_rddata[31:OW];
  assign accept    = cmd_valid && cmd_ready && (state == IDLE);
  assign busy      = (state != IDLE);
  assign src_inc   = (state == WR_HI) && !sel_q;
  assign dest_inc  = (state == WR_HI) && sel_q;

`ifdef VIDEO_CMD_ISSUER_CREDIT_EN
  logic [OW-1:0] credit_src, credit_dst;
  logic          credit_ok;

  assign credit_ok = cmd_sel ? (credit_dst != '0) : (credit_src != '0);

  // Credits count free slots known from the last poll, so polls can be skipped.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      credit_src <= '0;
      credit_dst <= '0;
    end else if (state == WAIT) begin
      if (sel_q) credit_dst <= q_full ? '0 : CAPACITY - occupancy;
      else       credit_src <= q_full ? '0 : CAPACITY - occupancy;
    end else if (state == WR_HI) begin
      if (sel_q && credit_dst != '0)       credit_dst <= credit_dst - 1'b1;
      else if (!sel_q && credit_src != '0) credit_src <= credit_src - 1'b1;
    end
  end
`endif

  always_comb begin
    next_state = state;
    gap_cnt_d  = gap_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef VIDEO_CMD_ISSUER_CREDIT_EN
          next_state = credit_ok ? WR_LO : POLL;
`else
          next_state = POLL;
`endif
        end
      end
      POLL: next_state = WAIT;
      WAIT: begin
        if (q_full) begin
          next_state = BACKOFF;
          gap_cnt_d  = GAP_LOAD;
        end else begin
          next_state = WR_LO;
        end
      end
      BACKOFF: begin
        if (gap_cnt == 8'd0) next_state = POLL;
        else                 gap_cnt_d  = gap_cnt - 8'd1;
      end
      WR_LO:   next_state = WR_HI;
      WR_HI:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Target strobes are decoded from the next state so they appear registered
  // in the same cycle the FSM occupies that state.
  always_comb begin
    sel_n    = accept ? cmd_sel : sel_q;
    data_n   = accept ? cmd_data : data_q;
    base_n   = sel_n ? 12'd8 : 12'd0;
    en_d     = 1'b0;
    we_d     = 4'h0;
    addr_d   = bram_addr;
    wrdata_d = bram_wrdata;
    case (next_state)
      POLL: begin
        en_d   = 1'b1;
        addr_d = base_n;
      end
      WR_LO: begin
        en_d     = 1'b1;
        we_d     = 4'hF;
        addr_d   = base_n;
        wrdata_d = data_n[31:0];
      end
      WR_HI: begin
        en_d     = 1'b1;
        we_d     = 4'hF;
        addr_d   = base_n + 12'd4;
        wrdata_d = data_n[63:32];
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state       <= IDLE;
      gap_cnt     <= 8'd0;
      sel_q       <= 1'b0;
      data_q      <= 64'd0;
      cmd_ready   <= 1'b0;
      bram_en     <= 1'b0;
      bram_we     <= 4'h0;
      bram_addr   <= 12'd0;
      bram_wrdata <= 32'd0;
      src_issued  <= 16'd0;
      dest_issued <= 16'd0;
    end else begin
      state       <= next_state;
      gap_cnt     <= gap_cnt_d;
      cmd_ready   <= (next_state == IDLE);
      bram_en     <= en_d;
      bram_we     <= we_d;
      bram_addr   <= addr_d;
      bram_wrdata <= wrdata_d;
      src_issued  <= src_issued + {15'd0, src_inc};
      dest_issued <= dest_issued + {15'd0, dest_inc};
      if (accept) begin
        sel_q  <= cmd_sel;
        data_q <= cmd_data;
      end
    end
  end

endmodule

// File: tb/tb_video_cmd_issuer.sv
// Scoreboard bench for video_cmd_issuer: a BRAM target model answers polls from
// an occupancy queue, and every write strobe is matched against queued expectations.
module tb_video_cmd_issuer;

  localparam int POLL_GAP = 4;

  logic        aclk = 1'b0;
  logic        arst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_sel;
  logic [63:0] cmd_data;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [11:0] bram_addr;
  logic [31:0] bram_wrdata;
  logic [31:0] bram_rddata = 32'd0;
  logic        busy;
  logic [15:0] src_issued;
  logic [15:0] dest_issued;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    int          kind;
    int          lat;
  } wr_t;

  wr_t         exp_q[$];
  int          occ_q[$];
  int          poll_times[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  int          last_wr_cyc = -100;
  int          poll_count = 0;
  logic [15:0] src_exp = 16'd0;
  logic [15:0] dest_exp = 16'd0;

  video_cmd_issuer #(.DEPTH_LOG2(7), .POLL_GAP(POLL_GAP)) dut (
    .aclk(aclk), .arst(arst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel), .cmd_data(cmd_data),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata),
    .busy(busy), .src_issued(src_issued), .dest_issued(dest_issued)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) accept_cyc <= cyc;
  end

  // Target model: read data appears the cycle after a read strobe.
  always @(posedge aclk) begin : target
    int v;
    v = 0;
    if (bram_en && bram_we == 4'h0) begin
      if (occ_q.size() > 0) v = occ_q.pop_front();
      bram_rddata <= 32'(v);
    end
  end

  always @(negedge aclk) begin : monitor
    wr_t e;
    if (!arst && bram_en && bram_we == 4'h0) begin
      poll_count++;
      poll_times.push_back(cyc);
    end
    if (!arst && bram_en && bram_we != 4'h0) begin
      checkOutput("wr_we", 64'(bram_we), 64'hF);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_wr", 64'(bram_en), 64'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("wr_addr", 64'(bram_addr), 64'(e.addr));
        checkOutput("wr_data", 64'(bram_wrdata), 64'(e.data));
        if (e.kind == 1) checkOutput("wr_latency", 64'(cyc - accept_cyc), 64'(e.lat));
        if (e.kind == 2) checkOutput("wr_pair_gap", 64'(cyc - last_wr_cyc), 64'd1);
      end
      last_wr_cyc = cyc;
    end
  end

  task automatic pushWrite(input logic [11:0] addr, input logic [31:0] data, input int kind, input int lat);
    wr_t e;
    e.addr = addr;
    e.data = data;
    e.kind = kind;
    e.lat  = lat;
    exp_q.push_back(e);
  endtask

  task automatic pushCmd(input logic sel, input logic [63:0] data, input int lat);
    logic [11:0] base;
    base = sel ? 12'd8 : 12'd0;
    pushWrite(base, data[31:0], (lat >= 0) ? 1 : 0, lat);
    pushWrite(base + 12'd4, data[63:32], 2, 0);
    if (sel) dest_exp++;
    else     src_exp++;
  endtask

  // Called at a falling edge with cmd_valid high; returns at the falling edge after the accept.
  task automatic waitAccept();
    int n = 0;
    while (!cmd_ready && n < 400) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 400) checkOutput("accept_timeout", 64'(cmd_ready), 64'd1);
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic applyStimulus(input logic sel, input logic [63:0] data, input int lat, input bit hold);
    pushCmd(sel, data, lat);
    cmd_sel   = sel;
    cmd_data  = data;
    cmd_valid = 1'b1;
    waitAccept();
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 500) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 500) checkOutput("idle_timeout", 64'(busy), 64'd0);
    @(negedge aclk);
  endtask

  initial begin : stim
    int p0;
    int t0;
    int lat;
    int n;
    arst      = 1'b0;
    cmd_valid = 1'b0;
    cmd_sel   = 1'b0;
    cmd_data  = 64'd0;
    #1 arst = 1'b1;
    repeat (3) @(negedge aclk);

    checkOutput("rst_ready", 64'(cmd_ready), 64'd0);
    checkOutput("rst_en", 64'(bram_en), 64'd0);
    checkOutput("rst_we", 64'(bram_we), 64'd0);
    checkOutput("rst_addr", 64'(bram_addr), 64'd0);
    checkOutput("rst_wrdata", 64'(bram_wrdata), 64'd0);
    checkOutput("rst_src", 64'(src_issued), 64'd0);
    checkOutput("rst_dest", 64'(dest_issued), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    arst = 1'b0;
    #1 checkOutput("ready_before_edge", 64'(cmd_ready), 64'd0);
    @(negedge aclk);
    checkOutput("ready_after_edge", 64'(cmd_ready), 64'd1);

    // Source command into an empty queue.
    occ_q.push_back(0);
    applyStimulus(1'b0, 64'h1122334455667788, 3, 1'b0);
    waitIdle();
    checkOutput("src_after_first", 64'(src_issued), 64'(src_exp));
    checkOutput("dest_after_first", 64'(dest_issued), 64'(dest_exp));

    // Destination queue full twice: two backoff periods between polls.
    p0 = poll_count;
    t0 = poll_times.size();
    occ_q.push_back(128);
    occ_q.push_back(128);
    occ_q.push_back(127);
    applyStimulus(1'b1, 64'hCAFEF00DDEADBEEF, 3 + 2 * (2 + POLL_GAP), 1'b0);
    waitIdle();
    checkOutput("full_poll_count", 64'(poll_count - p0), 64'd3);
    checkOutput("poll_spacing_1", 64'(poll_times[t0 + 1] - poll_times[t0]), 64'(2 + POLL_GAP));
    checkOutput("poll_spacing_2", 64'(poll_times[t0 + 2] - poll_times[t0 + 1]), 64'(2 + POLL_GAP));
    checkOutput("dest_after_full", 64'(dest_issued), 64'(dest_exp));

    // Reset between the two halves abandons the command.
    pushWrite(12'd0, 32'h89ABCDEF, 0, 0);
    cmd_sel   = 1'b0;
    cmd_data  = 64'h01234567_89ABCDEF;
    cmd_valid = 1'b1;
    waitAccept();
    cmd_valid = 1'b0;
    n = 0;
    while (!(bram_en && bram_we == 4'hF) && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 100) checkOutput("wr_lo_timeout", 64'(bram_en), 64'd1);
    #1 arst = 1'b1;
    src_exp  = 16'd0;
    dest_exp = 16'd0;
    repeat (2) @(negedge aclk);
    checkOutput("abort_en_in_rst", 64'(bram_en), 64'd0);
    checkOutput("abort_ready_in_rst", 64'(cmd_ready), 64'd0);
    arst = 1'b0;
    #1 checkOutput("abort_ready_pre_edge", 64'(cmd_ready), 64'd0);
    @(negedge aclk);
    checkOutput("abort_ready_post_edge", 64'(cmd_ready), 64'd1);
    checkOutput("abort_no_wr_hi", 64'(bram_en), 64'd0);
    checkOutput("abort_src", 64'(src_issued), 64'd0);
    checkOutput("abort_dest", 64'(dest_issued), 64'd0);
    checkOutput("abort_pending", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge aclk);

    // Sixteen back-to-back source commands.
    p0 = poll_count;
    occ_q.delete();
    occ_q.push_back(120);
    occ_q.push_back(0);
    for (int i = 0; i < 16; i++) begin
      lat = 3;
`ifdef VIDEO_CMD_ISSUER_CREDIT_EN
      if (i != 0 && i != 8) lat = 1;
`endif
      applyStimulus(1'b0, {16'hC0DE, 16'(i), 32'h10000000 + 32'(i)}, lat, i < 15);
    end
    waitIdle();
`ifdef VIDEO_CMD_ISSUER_CREDIT_EN
    checkOutput("burst_poll_count", 64'(poll_count - p0), 64'd2);
`else
    checkOutput("burst_poll_count", 64'(poll_count - p0), 64'd16);
`endif
    checkOutput("burst_src", 64'(src_issued), 64'(src_exp));

    // cmd_valid held through a busy period with the data changing underneath.
    pushCmd(1'b1, 64'hAAAA0001_AAAA0002, 3);
`ifdef VIDEO_CMD_ISSUER_CREDIT_EN
    pushCmd(1'b1, 64'hBBBB0001_BBBB0002, 1);
`else
    pushCmd(1'b1, 64'hBBBB0001_BBBB0002, 3);
`endif
    cmd_sel   = 1'b1;
    cmd_data  = 64'hAAAA0001_AAAA0002;
    cmd_valid = 1'b1;
    waitAccept();
    cmd_data = 64'hBBBB0001_BBBB0002;
    n = 0;
    while (busy && n < 50) begin
      checkOutput("ready_while_busy", 64'(cmd_ready), 64'd0);
      @(negedge aclk);
      n++;
    end
    waitAccept();
    cmd_valid = 1'b0;
    waitIdle();
    checkOutput("held_dest", 64'(dest_issued), 64'(dest_exp));

    // Counter wrap from a preset of 65535 issued commands.
    force dut.src_issued = 16'hFFFF;
    @(posedge aclk);
    @(negedge aclk);
    release dut.src_issued;
    src_exp = 16'hFFFF;
    @(negedge aclk);
    checkOutput("src_preset", 64'(src_issued), 64'(src_exp));
    applyStimulus(1'b0, 64'h0BADF00D_FEEDFACE, -1, 1'b0);
    waitIdle();
    checkOutput("src_wrap", 64'(src_issued), 64'(src_exp));

    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
